// File: rtl/tft_raster_gen.sv
// -----------------------------------------------------------------------------
// tft_raster_gen
//
// Purpose
//   Raster timing generator and compositor for a parallel-RGB TFT panel.
//   Free-running horizontal/vertical counters describe a configurable raster.
//   A power sequencer brings the panel up (vdd -> display -> backlight) and
//   down again on whole-frame boundaries. Up to N_BOX solid rectangles are
//   painted over a background colour. Box geometry and colours are captured
//   once per frame, so a box never tears.
//
// Pixel pipeline (2 stages, both in tft_clk)
//   stage 1 : counters, active flag, frame-start flag, box-hit vector
//   stage 2 : x, y, tft_data_ena, rgb and new_frame, all for one pixel
//
// Ports
//   tft_clk        pixel clock, the only clock
//   rst            synchronous reset, active high
//   enable         request panel on (1) / off (0)
//   box_en         per-box visibility
//   box_x / box_y  box left/top edges, box i at [i*XW +: XW] / [i*YW +: YW]
//   box_rgb        box colours {r,g,b}, box i at [i*24 +: 24]
//   bg_rgb         background colour
//   tft_vdd        panel supply enable
//   tft_display    panel display enable
//   tft_backlight  backlight enable
//   tft_data_ena   pixel valid
//   tft_red/green/blue  pixel colour, 0 whenever tft_data_ena is 0
//   x / y          column/row of the current output pixel (valid in blanking)
//   new_frame      one-cycle pulse when the output pixel is (0,0)
//   pwr_ready      high while the sequencer is in RUN
// -----------------------------------------------------------------------------
module tft_raster_gen #(
   parameter int H_ACTIVE   = 480,
   parameter int H_TOTAL    = 525,
   parameter int V_ACTIVE   = 272,
   parameter int V_TOTAL    = 288,
   parameter int XW         = 10,
   parameter int YW         = 9,
   parameter int N_BOX      = 2,
   parameter int BOX_W      = 20,
   parameter int BOX_H      = 20,
   parameter int PWR_FRAMES = 2
) (
   input  logic                tft_clk,
   input  logic                rst,
   input  logic                enable,
   input  logic [N_BOX-1:0]    box_en,
   input  logic [N_BOX*XW-1:0] box_x,
   input  logic [N_BOX*YW-1:0] box_y,
   input  logic [N_BOX*24-1:0] box_rgb,
   input  logic [23:0]         bg_rgb,
   output logic                tft_vdd,
   output logic                tft_display,
   output logic                tft_backlight,
   output logic                tft_data_ena,
   output logic [7:0]          tft_red,
   output logic [7:0]          tft_green,
   output logic [7:0]          tft_blue,
   output logic [XW-1:0]       x,
   output logic [YW-1:0]       y,
   output logic                new_frame,
   output logic                pwr_ready
);

   // Frame counter only needs to reach PWR_FRAMES-1.
   localparam int FW = (PWR_FRAMES > 1) ? $clog2(PWR_FRAMES) : 1;

   localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
   localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
   localparam logic [XW:0]   H_ACT_EXT = (XW + 1)'(H_ACTIVE);
   localparam logic [YW:0]   V_ACT_EXT = (YW + 1)'(V_ACTIVE);
   localparam logic [XW:0]   BOX_W_EXT = (XW + 1)'(BOX_W);
   localparam logic [YW:0]   BOX_H_EXT = (YW + 1)'(BOX_H);
   localparam logic [FW-1:0] PF_LAST   = FW'(PWR_FRAMES - 1);

   typedef enum logic [2:0] {
      ST_OFF  = 3'd0,
      ST_VDD  = 3'd1,
      ST_DISP = 3'd2,
      ST_RUN  = 3'd3,
      ST_DOWN = 3'd4
   } pwr_state_t;

   // Column test at XW+1 bits so a box near the top of the coordinate
   // range cannot wrap around and reappear at the left edge.
   function automatic logic in_span_x(input logic [XW-1:0] p, input logic [XW-1:0] lo);
      logic [XW:0] hi;
      hi = {1'b0, lo} + BOX_W_EXT;
      return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < hi);
   endfunction

   // Row test at YW+1 bits, same reasoning as the column test.
   function automatic logic in_span_y(input logic [YW-1:0] p, input logic [YW-1:0] lo);
      logic [YW:0] hi;
      hi = {1'b0, lo} + BOX_H_EXT;
      return ({1'b0, p} >= {1'b0, lo}) && ({1'b0, p} < hi);
   endfunction

   // raster counters
   logic [XW-1:0]       hcnt_q, hcnt_d;
   logic [YW-1:0]       vcnt_q, vcnt_d;
   logic                frame_start_s;
   logic                active_s;

   // per-frame box set
   logic [N_BOX-1:0]    lat_en_q;
   logic [N_BOX*XW-1:0] lat_x_q;
   logic [N_BOX*YW-1:0] lat_y_q;
   logic [N_BOX*24-1:0] lat_rgb_q;
   logic [N_BOX-1:0]    eff_en_s;
   logic [N_BOX*XW-1:0] eff_x_s;
   logic [N_BOX*YW-1:0] eff_y_s;
   logic [N_BOX-1:0]    hit_s;

   // stage 1
   logic [XW-1:0]       s1_x_q;
   logic [YW-1:0]       s1_y_q;
   logic                s1_act_q;
   logic                s1_first_q;
   logic [N_BOX-1:0]    s1_hit_q;

   // stage 2
   logic [23:0]         pix_rgb_s;
   logic                ena_s;
   logic [XW-1:0]       x_q;
   logic [YW-1:0]       y_q;
   logic                ena_q;
   logic                nf_q;
   logic [23:0]         rgb_q;

   // power sequencer
   pwr_state_t          state_q;
   logic [FW-1:0]       fcnt_q;
   logic                vdd_q;
   logic                disp_q;
   logic                bl_q;
   logic                rdy_q;

   assign frame_start_s = (hcnt_q == '0) && (vcnt_q == '0);
   assign active_s      = ({1'b0, hcnt_q} < H_ACT_EXT) && ({1'b0, vcnt_q} < V_ACT_EXT);

   // Next raster position: hcnt wraps at H_TOTAL and carries into vcnt.
   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         if (vcnt_q == V_LAST) begin
            vcnt_d = '0;
         end else begin
            vcnt_d = vcnt_q + 1'b1;
         end
      end else begin
         hcnt_d = hcnt_q + 1'b1;
      end
   end

   // Raster counters, free-running in every power state.
   always_ff @(posedge tft_clk) begin
      if (rst) begin
         hcnt_q <= '0;
         vcnt_q <= '0;
      end else begin
         hcnt_q <= hcnt_d;
         vcnt_q <= vcnt_d;
      end
   end

   // Capture the box inputs once per frame, at counter position (0,0).
   always_ff @(posedge tft_clk) begin
      if (rst) begin
         lat_en_q  <= '0;
         lat_x_q   <= '0;
         lat_y_q   <= '0;
         lat_rgb_q <= '0;
      end else if (frame_start_s) begin
         lat_en_q  <= box_en;
         lat_x_q   <= box_x;
         lat_y_q   <= box_y;
         lat_rgb_q <= box_rgb;
      end
   end

   // Pixel (0,0) is evaluated in the same cycle the set is captured, so it
   // reads the inputs directly; every other pixel of the frame then sees the
   // identical values from the latch.
   assign eff_en_s = frame_start_s ? box_en : lat_en_q;
   assign eff_x_s  = frame_start_s ? box_x  : lat_x_q;
   assign eff_y_s  = frame_start_s ? box_y  : lat_y_q;

   // Box-hit vector for the current counter position.
   always_comb begin
      hit_s = '0;
      for (int i = 0; i < N_BOX; i++) begin
         hit_s[i] = eff_en_s[i]
                    && in_span_x(hcnt_q, eff_x_s[i*XW +: XW])
                    && in_span_y(vcnt_q, eff_y_s[i*YW +: YW]);
      end
   end

   // Pipeline stage 1: position, active flag, frame-start flag and hits.
   always_ff @(posedge tft_clk) begin
      if (rst) begin
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_act_q   <= 1'b0;
         s1_first_q <= 1'b0;
         s1_hit_q   <= '0;
      end else begin
         s1_x_q     <= hcnt_q;
         s1_y_q     <= vcnt_q;
         s1_act_q   <= active_s;
         s1_first_q <= frame_start_s;
         s1_hit_q   <= hit_s;
      end
   end

   // Priority select: walking from the highest index down lets the lowest
   // hit index overwrite the others; background when nothing hits.
   always_comb begin
      pix_rgb_s = bg_rgb;
      for (int i = N_BOX - 1; i >= 0; i--) begin
         pix_rgb_s = s1_hit_q[i] ? lat_rgb_q[i*24 +: 24] : pix_rgb_s;
      end
   end

   assign ena_s = s1_act_q && disp_q;

   // Pipeline stage 2: all pixel outputs registered together.
   always_ff @(posedge tft_clk) begin
      if (rst) begin
         x_q   <= '0;
         y_q   <= '0;
         ena_q <= 1'b0;
         nf_q  <= 1'b0;
         rgb_q <= '0;
      end else begin
         x_q   <= s1_x_q;
         y_q   <= s1_y_q;
         ena_q <= ena_s;
         nf_q  <= s1_first_q;
         rgb_q <= ena_s ? pix_rgb_s : 24'h000000;
      end
   end

   // Power sequencer: each step waits PWR_FRAMES frame starts. Shutdown is
   // not interruptible; a new enable is honoured once OFF is reached.
   always_ff @(posedge tft_clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         fcnt_q  <= '0;
         vdd_q   <= 1'b0;
         disp_q  <= 1'b0;
         bl_q    <= 1'b0;
         rdy_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (enable) begin
                  state_q <= ST_VDD;
                  vdd_q   <= 1'b1;
                  fcnt_q  <= '0;
               end
            end
            ST_VDD: begin
               if (!enable) begin
                  state_q <= ST_DOWN;
                  fcnt_q  <= '0;
               end else if (frame_start_s) begin
                  if (fcnt_q == PF_LAST) begin
                     state_q <= ST_DISP;
                     disp_q  <= 1'b1;
                     fcnt_q  <= '0;
                  end else begin
                     fcnt_q  <= fcnt_q + 1'b1;
                  end
               end
            end
            ST_DISP: begin
               if (!enable) begin
                  state_q <= ST_DOWN;
                  fcnt_q  <= '0;
               end else if (frame_start_s) begin
                  if (fcnt_q == PF_LAST) begin
                     state_q <= ST_RUN;
                     bl_q    <= 1'b1;
                     rdy_q   <= 1'b1;
                     fcnt_q  <= '0;
                  end else begin
                     fcnt_q  <= fcnt_q + 1'b1;
                  end
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  state_q <= ST_DOWN;
                  bl_q    <= 1'b0;
                  rdy_q   <= 1'b0;
                  fcnt_q  <= '0;
               end
            end
            ST_DOWN: begin
               if (frame_start_s) begin
                  if (fcnt_q == PF_LAST) begin
                     state_q <= ST_OFF;
                     vdd_q   <= 1'b0;
                     disp_q  <= 1'b0;
                     fcnt_q  <= '0;
                  end else begin
                     fcnt_q  <= fcnt_q + 1'b1;
                  end
               end
            end
            default: begin
               state_q <= ST_OFF;
               fcnt_q  <= '0;
               vdd_q   <= 1'b0;
               disp_q  <= 1'b0;
               bl_q    <= 1'b0;
               rdy_q   <= 1'b0;
            end
         endcase
      end
   end

   assign tft_vdd       = vdd_q;
   assign tft_display   = disp_q;
   assign tft_backlight = bl_q;
   assign pwr_ready     = rdy_q;
   assign tft_data_ena  = ena_q;
   assign tft_red       = rgb_q[23:16];
   assign tft_green     = rgb_q[15:8];
   assign tft_blue      = rgb_q[7:0];
   assign x             = x_q;
   assign y             = y_q;
   assign new_frame     = nf_q;

endmodule

// File: tb/tb_tft_raster_gen.sv
// -----------------------------------------------------------------------------
// tb_tft_raster_gen
//
// Drives tft_raster_gen with a reduced raster (30x20 total, 24x16 visible) so
// many frames fit in a short run. A reference model tracks the raster as a
// single pixel index modulo the frame size, the power sequence as named
// states with frame counts, and the box set per frame; every output is
// compared every cycle on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tft_raster_gen;

   localparam int H_ACTIVE   = 24;
   localparam int H_TOTAL    = 30;
   localparam int V_ACTIVE   = 16;
   localparam int V_TOTAL    = 20;
   localparam int XW         = 6;
   localparam int YW         = 5;
   localparam int N_BOX      = 3;
   localparam int BOX_W      = 5;
   localparam int BOX_H      = 4;
   localparam int PWR_FRAMES = 2;
   localparam int FRAME      = H_TOTAL * V_TOTAL;

   localparam int M_OFF  = 0;
   localparam int M_VDD  = 1;
   localparam int M_DISP = 2;
   localparam int M_RUN  = 3;
   localparam int M_DOWN = 4;

   logic                tft_clk = 1'b0;
   logic                rst;
   logic                enable;
   logic [N_BOX-1:0]    box_en;
   logic [N_BOX*XW-1:0] box_x;
   logic [N_BOX*YW-1:0] box_y;
   logic [N_BOX*24-1:0] box_rgb;
   logic [23:0]         bg_rgb;
   logic                tft_vdd, tft_display, tft_backlight, tft_data_ena;
   logic [7:0]          tft_red, tft_green, tft_blue;
   logic [XW-1:0]       x;
   logic [YW-1:0]       y;
   logic                new_frame, pwr_ready;

   int n_checks = 0;
   int n_errors = 0;

   // reference model state
   int          m_cnt;       // raster pixel index of the current cycle
   int          m_state;
   int          m_frames;    // frame starts seen in the current power step
   bit          m_vdd, m_disp, m_bl;
   bit          m_s1_v;      // a pixel is in flight toward the outputs
   int          m_s1_pix;
   bit          m_s1_bg;
   logic [23:0] m_s1_col;
   bit          f_en [N_BOX];
   int          f_x  [N_BOX];
   int          f_y  [N_BOX];
   logic [23:0] f_rgb[N_BOX];

   // expected outputs
   int          e_x, e_y;
   bit          e_ena, e_nf;
   logic [23:0] e_rgb;

   tft_raster_gen #(
      .H_ACTIVE(H_ACTIVE), .H_TOTAL(H_TOTAL), .V_ACTIVE(V_ACTIVE),
      .V_TOTAL(V_TOTAL), .XW(XW), .YW(YW), .N_BOX(N_BOX),
      .BOX_W(BOX_W), .BOX_H(BOX_H), .PWR_FRAMES(PWR_FRAMES)
   ) dut (
      .tft_clk      (tft_clk),
      .rst          (rst),
      .enable       (enable),
      .box_en       (box_en),
      .box_x        (box_x),
      .box_y        (box_y),
      .box_rgb      (box_rgb),
      .bg_rgb       (bg_rgb),
      .tft_vdd      (tft_vdd),
      .tft_display  (tft_display),
      .tft_backlight(tft_backlight),
      .tft_data_ena (tft_data_ena),
      .tft_red      (tft_red),
      .tft_green    (tft_green),
      .tft_blue     (tft_blue),
      .x            (x),
      .y            (y),
      .new_frame    (new_frame),
      .pwr_ready    (pwr_ready)
   );

   always #5 tft_clk = ~tft_clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp_v, $time);
      end
   endtask

   // Colour the spec rules give to raster index p under the current frame set.
   task automatic pixel_colour(input int p, output bit is_bg, output logic [23:0] col);
      int h, v;
      h = p % H_TOTAL;
      v = p / H_TOTAL;
      is_bg = 1'b1;
      col   = 24'h000000;
      for (int i = 0; i < N_BOX; i++) begin
         if (is_bg && f_en[i] && h >= f_x[i] && h < f_x[i] + BOX_W
             && v >= f_y[i] && v < f_y[i] + BOX_H) begin
            is_bg = 1'b0;
            col   = f_rgb[i];
         end
      end
   endtask

   // Advance the model by one rising edge.
   task automatic model_step();
      bit disp_before, fs, act;
      int ph, pv;
      if (rst) begin
         m_cnt = 0; m_state = M_OFF; m_frames = 0;
         m_vdd = 1'b0; m_disp = 1'b0; m_bl = 1'b0;
         m_s1_v = 1'b0; m_s1_pix = 0; m_s1_bg = 1'b1; m_s1_col = 24'h000000;
         for (int i = 0; i < N_BOX; i++) begin
            f_en[i] = 1'b0; f_x[i] = 0; f_y[i] = 0; f_rgb[i] = 24'h000000;
         end
         e_x = 0; e_y = 0; e_ena = 1'b0; e_nf = 1'b0; e_rgb = 24'h000000;
      end else begin
         disp_before = m_disp;
         // the pixel evaluated last cycle reaches the outputs now
         if (m_s1_v) begin
            ph    = m_s1_pix % H_TOTAL;
            pv    = m_s1_pix / H_TOTAL;
            act   = (ph < H_ACTIVE) && (pv < V_ACTIVE);
            e_x   = ph;
            e_y   = pv;
            e_nf  = (m_s1_pix == 0);
            e_ena = act && disp_before;
            e_rgb = e_ena ? (m_s1_bg ? bg_rgb : m_s1_col) : 24'h000000;
         end
         fs = (m_cnt == 0);
         if (fs) begin
            for (int i = 0; i < N_BOX; i++) begin
               f_en[i]  = box_en[i];
               f_x[i]   = int'(box_x[i*XW +: XW]);
               f_y[i]   = int'(box_y[i*YW +: YW]);
               f_rgb[i] = box_rgb[i*24 +: 24];
            end
         end
         pixel_colour(m_cnt, m_s1_bg, m_s1_col);
         m_s1_pix = m_cnt;
         m_s1_v   = 1'b1;
         case (m_state)
            M_OFF: if (enable) begin m_state = M_VDD; m_vdd = 1'b1; m_frames = 0; end
            M_VDD: begin
               if (!enable) begin m_state = M_DOWN; m_frames = 0; end
               else if (fs) begin
                  m_frames++;
                  if (m_frames == PWR_FRAMES) begin m_state = M_DISP; m_disp = 1'b1; m_frames = 0; end
               end
            end
            M_DISP: begin
               if (!enable) begin m_state = M_DOWN; m_frames = 0; end
               else if (fs) begin
                  m_frames++;
                  if (m_frames == PWR_FRAMES) begin m_state = M_RUN; m_bl = 1'b1; m_frames = 0; end
               end
            end
            M_RUN: if (!enable) begin m_state = M_DOWN; m_bl = 1'b0; m_frames = 0; end
            M_DOWN: begin
               if (fs) begin
                  m_frames++;
                  if (m_frames == PWR_FRAMES) begin
                     m_state = M_OFF; m_vdd = 1'b0; m_disp = 1'b0; m_frames = 0;
                  end
               end
            end
            default: m_state = M_OFF;
         endcase
         m_cnt = (m_cnt + 1) % FRAME;
      end
   endtask

   task automatic compare_outputs();
      check_val("x",         32'(x),            32'(e_x));
      check_val("y",         32'(y),            32'(e_y));
      check_val("data_ena",  32'(tft_data_ena), 32'(e_ena));
      check_val("rgb",       32'({tft_red, tft_green, tft_blue}), 32'(e_rgb));
      check_val("new_frame", 32'(new_frame),    32'(e_nf));
      check_val("vdd",       32'(tft_vdd),      32'(m_vdd));
      check_val("display",   32'(tft_display),  32'(m_disp));
      check_val("backlight", 32'(tft_backlight), 32'(m_bl));
      check_val("pwr_ready", 32'(pwr_ready),    32'(m_bl));
      if (tft_data_ena) check_val("x_visible", 32'(int'(x) < H_ACTIVE), 32'd1);
   endtask

   task automatic run(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge tft_clk);
         model_step();
         @(negedge tft_clk);
         compare_outputs();
      end
   endtask

   task automatic set_box(input int i, input bit en, input int bx, input int by, input logic [23:0] col);
      box_en[i]          = en;
      box_x[i*XW +: XW]  = XW'(bx);
      box_y[i*YW +: YW]  = YW'(by);
      box_rgb[i*24 +: 24] = col;
   endtask

   task automatic random_boxes();
      for (int i = 0; i < N_BOX; i++) begin
         set_box(i, ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, (1 << XW) - 1)),
                 int'($urandom_range(0, (1 << YW) - 1)),
                 24'($urandom()));
      end
      bg_rgb = 24'($urandom());
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0;
      box_en = '0; box_x = '0; box_y = '0; box_rgb = '0; bg_rgb = 24'h000000;

      // reset, then a panel that stays off
      run(10);
      rst = 1'b0;
      run(2 * FRAME);

      // power-up with enable present at reset release, single box
      rst = 1'b1;
      run(3);
      set_box(0, 1'b1, 5, 5, 24'hFF0000);
      bg_rgb = 24'h0000FF;
      enable = 1'b1;
      rst = 1'b0;
      run(5 * FRAME);

      // overlapping boxes: lower index wins
      set_box(0, 1'b1, 8, 8, 24'h00FF00);
      set_box(1, 1'b1, 10, 10, 24'hFFFFFF);
      set_box(2, 1'b1, 11, 9, 24'h123456);
      run(FRAME);

      // move a box mid-frame: takes effect the next frame
      run(5 * H_TOTAL + 7);
      set_box(0, 1'b1, 15, 8, 24'h00FF00);
      run(2 * FRAME);

      // clipping at the visible edge and no wrap near the coordinate limit
      set_box(0, 1'b1, 22, 14, 24'hABCDEF);
      set_box(1, 1'b1, 62, 30, 24'h777777);
      set_box(2, 1'b1, 0, 0, 24'h010203);
      run(FRAME);

      // random box sets changing at random points
      for (int k = 0; k < 12; k++) begin
         random_boxes();
         run(int'($urandom_range(50, FRAME)));
      end

      // shutdown from RUN
      enable = 1'b0;
      run(3 * FRAME);

      // power up, then re-enable during shutdown
      enable = 1'b1;
      run(5 * FRAME);
      enable = 1'b0;
      run(100);
      enable = 1'b1;
      run(8 * FRAME);

      // enable dropped during VDD, then during DISP
      enable = 1'b0;
      run(3 * FRAME);
      enable = 1'b1;
      run(FRAME);
      enable = 1'b0;
      run(3 * FRAME);
      enable = 1'b1;
      run(FRAME * 5 / 2);
      enable = 1'b0;
      run(3 * FRAME);

      // random enable and box activity
      for (int k = 0; k < 10; k++) begin
         enable = ($urandom_range(0, 2) != 0);
         random_boxes();
         run(int'($urandom_range(100, 2 * FRAME)));
      end

      // reset in the middle of operation
      enable = 1'b1;
      run(5 * FRAME);
      rst = 1'b1;
      run(2);
      rst = 1'b0;
      run(FRAME);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
